// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - request/result handshakes and ALU control bundle for alu_sequencer
// Purpose: carries the request handshake, the result handshake and the
// operand/control bus to the external 16-bit combinational ALU.
// Ports (signals):
//   in_valid/in_ready/in_op[2:0]/in_a[15:0]/in_b[15:0] : request handshake
//   out_valid/out_ready/out_result[15:0]/out_flags[3:0] : result handshake, flags {C,Z,N,V}
//   alu_a/alu_b[15:0], alu_ci/alu_nb/alu_ic/alu_zb      : ALU operands and controls
//   alu_out[15:0], alu_co                               : ALU sum and carry-out
// Modports: master = requester/consumer/ALU side, slave = the sequencer.
interface alu_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_flags;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_ci;
    logic        alu_nb;
    logic        alu_ic;
    logic        alu_zb;
    logic [15:0] alu_out;
    logic        alu_co;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready, alu_out, alu_co,
        input  in_ready, out_valid, out_result, out_flags,
               alu_a, alu_b, alu_ci, alu_nb, alu_ic, alu_zb
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready, alu_out, alu_co,
        output in_ready, out_valid, out_result, out_flags,
               alu_a, alu_b, alu_ci, alu_nb, alu_ic, alu_zb
    );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - operand issue and result capture stage around a 16-bit ALU
// Purpose: accepts one opcode plus operands, drives the external ALU, and
// registers the result and a persistent {C,Z,N,V} flag set. Opcode 7 is a
// 16-iteration shift-add multiply when ALU_SEQ_MUL_EN is defined, otherwise
// a one-cycle pass-through of operand a.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : alu_sequencer_if.slave (request, result and ALU buses)
// Build option: ALU_SEQ_MUL_EN enables the multiply state, counter and shifters.
module alu_sequencer (
    input logic            clk,
    input logic            rst,
    alu_sequencer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBB = 3'd3;
    localparam logic [2:0] OP_INC = 3'd4;
    localparam logic [2:0] OP_DEC = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_result;
    logic [3:0]  r_flags;

    logic [15:0] w_alu_a;
    logic [15:0] w_alu_b;
    logic        w_ci;
    logic        w_nb;
    logic        w_ic;
    logic        w_zb;
    logic        w_accept;
    logic        w_arith;
    logic        w_y15;
    logic        w_v;
    logic        w_z;
    logic [3:0]  w_exec_flags;

`ifdef ALU_SEQ_MUL_EN
    // r_a doubles as the shifting multiplicand and r_b as the shifting multiplier.
    logic [3:0]  r_cnt;
    logic [15:0] r_acc;
`endif

    assign w_accept = bus.in_valid && (r_state == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_alu_a      = 16'h0000;
        w_alu_b      = 16'h0000;
        w_ci         = 1'b0;
        w_nb         = 1'b0;
        w_ic         = 1'b0;
        w_zb         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
`ifdef ALU_SEQ_MUL_EN
                    w_state_next = (bus.in_op == OP_MUL) ? S_MUL : S_EXEC;
`else
                    w_state_next = S_EXEC;
`endif
                end
            end
            S_EXEC: begin
                w_state_next = S_DONE;
                w_alu_a      = r_a;
                w_alu_b      = r_b;
                case (r_op)
                    OP_ADD: ;
                    OP_ADC: w_ci = r_flags[3];
                    OP_SUB: begin w_ci = 1'b1; w_nb = 1'b1; end
                    OP_SBB: begin w_ci = r_flags[3]; w_nb = 1'b1; end
                    OP_INC: begin w_ci = 1'b1; w_zb = 1'b1; end
                    OP_DEC: begin w_nb = 1'b1; w_zb = 1'b1; end
                    OP_XOR: w_ic = 1'b1;
                    default: begin w_ic = 1'b1; w_zb = 1'b1; end  // pass-through of a
                endcase
            end
            S_MUL: begin
`ifdef ALU_SEQ_MUL_EN
                w_alu_a = r_acc;
                w_alu_b = r_a;
                // Multiplier bit clear: pass acc through unchanged (a ^ 0).
                if (!r_b[0]) begin
                    w_ic = 1'b1;
                    w_zb = 1'b1;
                end
                if (r_cnt == 4'd15) begin
                    w_state_next = S_DONE;
                end
`else
                w_state_next = S_IDLE;
`endif
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Overflow uses the effective b sign after zeroing/inversion, so it covers
    // SUB/SBB/DEC with the same expression as ADD.
    assign w_y15        = (r_b[15] & ~w_zb) ^ w_nb;
    assign w_v          = (r_a[15] == w_y15) && (bus.alu_out[15] != r_a[15]);
    assign w_arith      = (r_op <= OP_DEC);
    assign w_z          = (bus.alu_out == 16'h0000);
    assign w_exec_flags = {w_arith & bus.alu_co, w_z, bus.alu_out[15], w_arith & w_v};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= 3'd0;
            r_a      <= 16'h0000;
            r_b      <= 16'h0000;
            r_result <= 16'h0000;
            r_flags  <= 4'h0;
`ifdef ALU_SEQ_MUL_EN
            r_cnt    <= 4'd0;
            r_acc    <= 16'h0000;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op <= bus.in_op;
                        r_a  <= bus.in_a;
                        r_b  <= bus.in_b;
`ifdef ALU_SEQ_MUL_EN
                        r_cnt <= 4'd0;
                        r_acc <= 16'h0000;
`endif
                    end
                end
                S_EXEC: begin
                    r_result <= bus.alu_out;
                    r_flags  <= w_exec_flags;
                end
`ifdef ALU_SEQ_MUL_EN
                S_MUL: begin
                    r_acc <= bus.alu_out;
                    r_a   <= {r_a[14:0], 1'b0};
                    r_b   <= {1'b0, r_b[15:1]};
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_result <= bus.alu_out;
                        r_flags  <= {1'b0, w_z, bus.alu_out[15], 1'b0};
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == S_IDLE);
    assign bus.out_valid  = (r_state == S_DONE);
    assign bus.out_result = r_result;
    assign bus.out_flags  = r_flags;
    assign bus.alu_a      = w_alu_a;
    assign bus.alu_b      = w_alu_b;
    assign bus.alu_ci     = w_ci;
    assign bus.alu_nb     = w_nb;
    assign bus.alu_ic     = w_ic;
    assign bus.alu_zb     = w_zb;
endmodule
